oq_regs_counter_ram: RTL and testbench

OQ_REGS_COUNTER_RAM -- requirements
Module: oq_regs_counter_ram

---
 rtl/oq_regs_pkg.sv | 24 ++
 rtl/oq_regs_tdp_array.sv | 35 +++
 rtl/oq_regs_counter_ram.sv | 220 ++++++++++++++++++++++
 tb/tb_oq_regs_counter_ram.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/oq_regs_pkg.sv
// Shared definitions for the output-queue counter RAM: state encoding, address-width
// helper and the even-parity helper used when OQ_REGS_RAM_PARITY_EN is defined.
package oq_regs_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Ceiling log2, never below 1 so a two-word RAM still gets a one-bit address.
   function automatic int log2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic even_parity(input logic [255:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/oq_regs_tdp_array.sv
// Dual-port storage array, block-RAM style: synchronous read-before-write on both ports,
// no reset on contents or read registers.
module oq_regs_tdp_array #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] waddr_a,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] waddr_b,
   input  logic [DATA_W-1:0] wdata_b,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_a_q;
   logic [DATA_W-1:0] rdata_b_q;

   // The two write addresses never coincide; the caller merges same-address traffic.
   always_ff @(posedge clk) begin
      rdata_a_q <= mem[raddr_a];
      rdata_b_q <= mem[raddr_b];
      if (we_a) mem[waddr_a] <= wdata_a;
      if (we_b) mem[waddr_b] <= wdata_b;
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;

endmodule

// File: rtl/oq_regs_counter_ram.sv
// Dual-port counter RAM with power-up clear sweep, two-stage add and same-address merge.
// Define OQ_REGS_RAM_PARITY_EN to store and check one even-parity bit per word.
module oq_regs_counter_ram
   import oq_regs_pkg::*;
#(
   parameter int                   REG_WIDTH           = 32,
   parameter int                   NUM_OUTPUT_QUEUES   = 8,
   parameter int                   REG_FILE_ADDR_WIDTH = log2(NUM_OUTPUT_QUEUES),
   parameter logic [REG_WIDTH-1:0] INIT_VALUE          = '0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   output logic                           ready,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] addr_a,
   input  logic                           we_a,
   input  logic                           add_a,
   input  logic [REG_WIDTH-1:0]           din_a,
   output logic [REG_WIDTH-1:0]           dout_a,
   input  logic [REG_FILE_ADDR_WIDTH-1:0] addr_b,
   input  logic                           we_b,
   input  logic                           add_b,
   input  logic [REG_WIDTH-1:0]           din_b,
   output logic [REG_WIDTH-1:0]           dout_b,
   output logic                           collision,
   output logic                           parity_err_a,
   output logic                           parity_err_b
);

   localparam int W  = REG_WIDTH;
   localparam int AW = REG_FILE_ADDR_WIDTH;
`ifdef OQ_REGS_RAM_PARITY_EN
   localparam int DW = W + 1;
`else
   localparam int DW = W;
`endif
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_OUTPUT_QUEUES - 1);

   state_e          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            rel_q;
   logic            sweep_we;
   logic            ready_q, ready_d;
   logic            collision_q, collision_d;
   logic            dvld_q, dvld_d;

   // Issue stage: one retiring operation per port, written to the array one edge after issue.
   logic            sa_vld_q, sa_vld_d, sb_vld_q, sb_vld_d;
   logic            sa_add_q, sa_add_d, sb_add_q, sb_add_d;
   logic [AW-1:0]   sa_addr_q, sa_addr_d, sb_addr_q, sb_addr_d;
   logic [W-1:0]    sa_data_q, sa_data_d, sb_data_q, sb_data_d;
   logic            ba_vld_q, ba_vld_d, bb_vld_q, bb_vld_d;
   logic [W-1:0]    ba_val_q, ba_val_d, bb_val_q, bb_val_d;

   logic [DW-1:0]   ram_rd_a, ram_rd_b, ram_wd_a, ram_wd_b;
   logic            ram_we_a;
   logic [AW-1:0]   ram_wa_a;
   logic [W-1:0]    rd_a, rd_b, wval_a, wval_b, wdat_a;

   // The first rising edge after release only arms rel_q, so the sweep starts on the second.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rel_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_INIT && rel_q) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == LAST_ADDR) state_d = ST_READY;
      end
   end

   always_comb begin
      sweep_we = (state_q == ST_INIT) && rel_q;
      ready_d  = (state_q == ST_READY);
   end

   always_comb begin
      rd_a     = ba_vld_q ? ba_val_q : ram_rd_a[W-1:0];
      rd_b     = bb_vld_q ? bb_val_q : ram_rd_b[W-1:0];
      wval_a   = sa_add_q ? rd_a + sa_data_q : sa_data_q;
      wval_b   = sb_add_q ? rd_b + sb_data_q : sb_data_q;
      ram_we_a = sweep_we | sa_vld_q;
      ram_wa_a = sweep_we ? ptr_q : sa_addr_q;
      wdat_a   = sweep_we ? INIT_VALUE : wval_a;
   end

   // Same-address traffic is merged into the port B slot so the array never sees two writes to one word.
   always_comb begin
      sa_vld_d    = 1'b0;
      sa_add_d    = 1'b0;
      sa_addr_d   = addr_a;
      sa_data_d   = din_a;
      sb_vld_d    = 1'b0;
      sb_add_d    = 1'b0;
      sb_addr_d   = addr_b;
      sb_data_d   = din_b;
      collision_d = 1'b0;
      dvld_d      = ready_q;
      if (ready_q) begin
         if (we_a && we_b && addr_a == addr_b) begin
            collision_d = 1'b1;
            sb_vld_d    = 1'b1;
            if (add_a && add_b) begin
               sb_add_d  = 1'b1;
               sb_data_d = din_a + din_b;
            end else if (add_b) begin
               sb_data_d = din_a;
            end else begin
               sb_data_d = din_b;
            end
         end else begin
            sa_vld_d = we_a;
            sa_add_d = add_a;
            sb_vld_d = we_b;
            sb_add_d = add_b;
         end
      end
   end

   always_comb begin
      ba_vld_d = 1'b0;
      ba_val_d = '0;
      bb_vld_d = 1'b0;
      bb_val_d = '0;
      if (sa_vld_q && sa_addr_q == addr_a) begin
         ba_vld_d = 1'b1;
         ba_val_d = wval_a;
      end else if (sb_vld_q && sb_addr_q == addr_a) begin
         ba_vld_d = 1'b1;
         ba_val_d = wval_b;
      end
      if (sa_vld_q && sa_addr_q == addr_b) begin
         bb_vld_d = 1'b1;
         bb_val_d = wval_a;
      end else if (sb_vld_q && sb_addr_q == addr_b) begin
         bb_vld_d = 1'b1;
         bb_val_d = wval_b;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ready_q     <= 1'b0;
         collision_q <= 1'b0;
         dvld_q      <= 1'b0;
         sa_vld_q    <= 1'b0;
         sa_add_q    <= 1'b0;
         sa_addr_q   <= '0;
         sa_data_q   <= '0;
         sb_vld_q    <= 1'b0;
         sb_add_q    <= 1'b0;
         sb_addr_q   <= '0;
         sb_data_q   <= '0;
         ba_vld_q    <= 1'b0;
         ba_val_q    <= '0;
         bb_vld_q    <= 1'b0;
         bb_val_q    <= '0;
      end else begin
         ready_q     <= ready_d;
         collision_q <= collision_d;
         dvld_q      <= dvld_d;
         sa_vld_q    <= sa_vld_d;
         sa_add_q    <= sa_add_d;
         sa_addr_q   <= sa_addr_d;
         sa_data_q   <= sa_data_d;
         sb_vld_q    <= sb_vld_d;
         sb_add_q    <= sb_add_d;
         sb_addr_q   <= sb_addr_d;
         sb_data_q   <= sb_data_d;
         ba_vld_q    <= ba_vld_d;
         ba_val_q    <= ba_val_d;
         bb_vld_q    <= bb_vld_d;
         bb_val_q    <= bb_val_d;
      end
   end

`ifdef OQ_REGS_RAM_PARITY_EN
   assign ram_wd_a     = {even_parity(256'(wdat_a)), wdat_a};
   assign ram_wd_b     = {even_parity(256'(wval_b)), wval_b};
   assign parity_err_a = dvld_q && !ba_vld_q && even_parity(256'(ram_rd_a));
   assign parity_err_b = dvld_q && !bb_vld_q && even_parity(256'(ram_rd_b));
`else
   assign ram_wd_a     = wdat_a;
   assign ram_wd_b     = wval_b;
   assign parity_err_a = 1'b0;
   assign parity_err_b = 1'b0;
`endif

   oq_regs_tdp_array #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) u_array (
      .clk     (clk),
      .we_a    (ram_we_a),
      .waddr_a (ram_wa_a),
      .wdata_a (ram_wd_a),
      .raddr_a (addr_a),
      .rdata_a (ram_rd_a),
      .we_b    (sb_vld_q),
      .waddr_b (sb_addr_q),
      .wdata_b (ram_wd_b),
      .raddr_b (addr_b),
      .rdata_b (ram_rd_b)
   );

   assign ready     = ready_q;
   assign collision = collision_q;
   assign dout_a    = dvld_q ? rd_a : '0;
   assign dout_b    = dvld_q ? rd_b : '0;

endmodule

// File: tb/tb_oq_regs_counter_ram.sv
// Scoreboard bench for oq_regs_counter_ram: drivers push expected read data per issued cycle,
// a monitor pops one entry per cycle after the edge. Parity checks need OQ_REGS_RAM_PARITY_EN.
module tb_oq_regs_counter_ram;

   localparam int W  = 32;
   localparam int AW = 3;
   localparam int N  = 8;

   logic          clk;
   logic          reset_n;
   logic          ready;
   logic [AW-1:0] addr_a, addr_b;
   logic          we_a, we_b, add_a, add_b;
   logic [W-1:0]  din_a, din_b, dout_a, dout_b;
   logic          collision, parity_err_a, parity_err_b;

   typedef struct {
      logic [W-1:0] da;
      logic [W-1:0] db;
      logic         col;
      logic         pa;
      logic         pb;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] model [N];
   logic         issue_v;
   int           checks   = 0;
   int           failures = 0;

   oq_regs_counter_ram #(
      .REG_WIDTH         (W),
      .NUM_OUTPUT_QUEUES (N)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ready        (ready),
      .addr_a       (addr_a),
      .we_a         (we_a),
      .add_a        (add_a),
      .din_a        (din_a),
      .dout_a       (dout_a),
      .addr_b       (addr_b),
      .we_b         (we_b),
      .add_b        (add_b),
      .din_b        (din_b),
      .dout_b       (dout_b),
      .collision    (collision),
      .parity_err_a (parity_err_a),
      .parity_err_b (parity_err_b)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every issued cycle has exactly one queued expectation, visible after the edge.
   always @(posedge clk) begin
      logic pend;
      exp_t e;
      pend = issue_v;
      #1;
      if (pend) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=empty expected=entry");
         end else begin
            e = exp_q.pop_front();
            chk("dout_a", dout_a, e.da);
            chk("dout_b", dout_b, e.db);
            chk("collision", W'(collision), W'(e.col));
            chk("parity_err_a", W'(parity_err_a), W'(e.pa));
            chk("parity_err_b", W'(parity_err_b), W'(e.pb));
         end
      end
   end

   // Driver: issue one cycle of port operations; expected reads come from a sequential model.
   task automatic issue(input logic [AW-1:0] aa, input logic wa, input logic ada, input logic [W-1:0] da,
                        input logic [AW-1:0] ab, input logic wb, input logic adb, input logic [W-1:0] db);
      exp_t         e;
      logic [W-1:0] oa, ob;
      @(negedge clk);
      addr_a = aa; we_a = wa; add_a = ada; din_a = da;
      addr_b = ab; we_b = wb; add_b = adb; din_b = db;
      issue_v = 1'b1;
      oa = model[aa];
      ob = model[ab];
      e.da = oa; e.db = ob; e.col = wa && wb && (aa == ab); e.pa = 1'b0; e.pb = 1'b0;
      if (e.col) begin
         if (ada && adb)  model[aa] = oa + da + db;
         else if (ada)    model[aa] = db;
         else if (adb)    model[aa] = da;
         else             model[aa] = db;
      end else begin
         if (wa) model[aa] = ada ? oa + da : da;
         if (wb) model[ab] = adb ? ob + db : db;
      end
      exp_q.push_back(e);
   endtask

   // Driver: plain reads against hand-computed values.
   task automatic rd(input logic [AW-1:0] aa, input logic [W-1:0] ea,
                     input logic [AW-1:0] ab, input logic [W-1:0] eb, input logic epb);
      exp_t e;
      @(negedge clk);
      addr_a = aa; we_a = 1'b0; add_a = 1'b0; din_a = '0;
      addr_b = ab; we_b = 1'b0; add_b = 1'b0; din_b = '0;
      issue_v = 1'b1;
      e.da = ea; e.db = eb; e.col = 1'b0; e.pa = 1'b0; e.pb = epb;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         we_a = 1'b0; we_b = 1'b0; add_a = 1'b0; add_b = 1'b0;
         issue_v = 1'b0;
      end
   endtask

   // Reset, junk traffic during the sweep, and ready timing from release.
   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      issue_v = 1'b0;
      addr_a = 3'd3; we_a = 1'b1; add_a = 1'b0; din_a = 32'hDEAD_BEEF;
      addr_b = 3'd5; we_b = 1'b1; add_b = 1'b1; din_b = 32'd7;
      #1;
      chk("reset_ready", W'(ready), 32'd0);
      chk("reset_dout_a", dout_a, 32'd0);
      chk("reset_dout_b", dout_b, 32'd0);
      chk("reset_collision", W'(collision), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) model[i] = '0;
      repeat (5) @(posedge clk);
      #1;
      chk("sweep_dout_a", dout_a, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("ready_edge9", W'(ready), 32'd0);
      @(posedge clk);
      #1;
      chk("ready_edge10", W'(ready), 32'd1);
      idle(1);
   endtask

   initial begin
      reset_n = 1'b1;
      issue_v = 1'b0;
      addr_a = '0; we_a = 1'b0; add_a = 1'b0; din_a = '0;
      addr_b = '0; we_b = 1'b0; add_b = 1'b0; din_b = '0;
      for (int i = 0; i < N; i++) model[i] = '0;

      do_reset();
      for (int i = 0; i < N; i++) rd(AW'(i), 32'd0, AW'(N - 1 - i), 32'd0, 1'b0);

      // Accumulate on one address: reads 0, 5, 10, 15 then 20
      for (int i = 0; i < 4; i++) issue(3'd3, 1'b1, 1'b1, 32'd5, 3'd0, 1'b0, 1'b0, 32'd0);
      rd(3'd3, 32'd20, 3'd3, 32'd20, 1'b0);

      // Plain-write collision, B wins; following cycle shows collision low again
      issue(3'd2, 1'b1, 1'b0, 32'hAAAA, 3'd2, 1'b1, 1'b0, 32'h5555);
      rd(3'd2, 32'h5555, 3'd2, 32'h5555, 1'b0);

      // Double add on a freshly written word
      issue(3'd1, 1'b1, 1'b0, 32'd10, 3'd0, 1'b0, 1'b0, 32'd0);
      issue(3'd1, 1'b1, 1'b1, 32'd3, 3'd1, 1'b1, 1'b1, 32'd4);
      rd(3'd1, 32'd17, 3'd1, 32'd17, 1'b0);

      // Wraparound and independent addresses
      issue(3'd6, 1'b1, 1'b0, 32'hFFFF_FFFF, 3'd4, 1'b1, 1'b0, 32'h44);
      issue(3'd6, 1'b1, 1'b1, 32'd2, 3'd5, 1'b1, 1'b1, 32'h10);
      rd(3'd6, 32'd1, 3'd4, 32'h44, 1'b0);
      rd(3'd5, 32'h10, 3'd7, 32'd0, 1'b0);

      // Plain write beats add in either direction
      issue(3'd5, 1'b1, 1'b1, 32'd7, 3'd5, 1'b1, 1'b0, 32'd9);
      issue(3'd5, 1'b1, 1'b0, 32'd11, 3'd5, 1'b1, 1'b1, 32'd4);
      rd(3'd5, 32'd11, 3'd5, 32'd11, 1'b0);

      // Add forwarded to the other port; add_b without we_b is a read
      issue(3'd7, 1'b1, 1'b1, 32'd1, 3'd0, 1'b0, 1'b0, 32'd0);
      issue(3'd0, 1'b0, 1'b0, 32'd0, 3'd7, 1'b0, 1'b1, 32'd9);
      issue(3'd7, 1'b1, 1'b1, 32'd1, 3'd7, 1'b0, 1'b0, 32'd0);
      rd(3'd7, 32'd2, 3'd7, 32'd2, 1'b0);

`ifdef OQ_REGS_RAM_PARITY_EN
      idle(2);
      @(negedge clk);
      dut.u_array.mem[4] = dut.u_array.mem[4] ^ 33'd1;
      rd(3'd3, 32'd20, 3'd4, 32'h45, 1'b1);
      rd(3'd3, 32'd20, 3'd5, 32'd11, 1'b0);
`endif

      // Reset in the cycle after an add: add lost, sweep restores everything
      issue(3'd0, 1'b1, 1'b1, 32'd9, 3'd2, 1'b0, 1'b0, 32'd0);
      do_reset();
      rd(3'd0, 32'd0, 3'd2, 32'd0, 1'b0);
      rd(3'd1, 32'd0, 3'd3, 32'd0, 1'b0);
      idle(2);
      chk("scoreboard_drained", W'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
